// File: rtl/ac_pkg.sv
// Shared types and helpers for the AC zone scheduler: FSM encoding, temperature
// defaults and the unsigned absolute-difference helper.
package ac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStep,
    StWait,
    StRelease
  } ac_state_e;

  localparam int unsigned DefaultW    = 6;
  localparam int unsigned DefaultHyst = 1;

  // Widest temperature absdiff handles; callers zero-extend into this width so
  // the subtraction never wraps.
  localparam int unsigned MaxW = 16;

  function automatic logic [MaxW-1:0] absdiff(input logic [MaxW-1:0] a,
                                              input logic [MaxW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, modulo NZ.
module rr_arbiter #(
  parameter int unsigned NZ = 4,
  parameter int unsigned IW = 2
) (
  input  logic [NZ-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NZ-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NZ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NZ) j = j - NZ;
      if (!valid && req[j[IW-1:0]]) begin
        valid             = 1'b1;
        idx               = j[IW-1:0];
        gnt[j[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac_zone_scheduler.sv
// Time-shares one air-conditioner step engine between NZ zones, round-robin,
// granting a zone whose temperature sits outside the hysteresis band.
module ac_zone_scheduler
  import ac_pkg::*;
#(
  parameter int unsigned NZ      = 4,
  parameter int unsigned W       = DefaultW,
  parameter int unsigned QUANTUM = 4,
  parameter int unsigned HYST    = DefaultHyst
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NZ*W-1:0] zone_temp,
  input  logic [NZ*W-1:0] zone_ideal,
  input  logic [NZ-1:0]   zone_en,
  output logic [W-1:0]    ac_temp,
  output logic [W-1:0]    ac_ideal,
  output logic            ac_step,
  input  logic [W-1:0]    ac_out_temp,
  output logic [NZ-1:0]   grant,
  output logic            busy,
  output logic            done,
  output logic [2:0]      done_zone,
  output logic            done_reached,
  output logic            done_aborted,
  output logic [W-1:0]    cur_temp
);

  localparam int unsigned IW = (NZ > 1) ? $clog2(NZ) : 1;

  ac_state_e     state_q;
  logic [IW-1:0] rr_ptr_q, g_q;
  logic [W-1:0]  work_q, ideal_q, ac_temp_q, ac_ideal_q;
  logic [3:0]    qcnt_q;
  logic [NZ-1:0] grant_q;
  logic          busy_q, done_q, done_reached_q, done_aborted_q, ac_step_q;
  logic [2:0]    done_zone_q;

  logic [NZ-1:0] req, arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          arb_valid;
  logic [W-1:0]  sel_temp, sel_ideal;
  logic          sel_en;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NZ; i++) begin
      req[i] = zone_en[i] &&
               (absdiff(MaxW'(zone_temp[i*W +: W]), MaxW'(zone_ideal[i*W +: W])) >
                MaxW'(HYST));
    end
  end

  // Inputs of the granted zone; only the enable is watched after LOAD.
  always_comb begin
    sel_temp  = '0;
    sel_ideal = '0;
    sel_en    = 1'b0;
    for (int unsigned i = 0; i < NZ; i++) begin
      if (g_q == IW'(i)) begin
        sel_temp  = zone_temp[i*W +: W];
        sel_ideal = zone_ideal[i*W +: W];
        sel_en    = zone_en[i];
      end
    end
  end

  rr_arbiter #(
    .NZ(NZ),
    .IW(IW)
  ) u_rr_arbiter (
    .req  (req),
    .ptr  (rr_ptr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .valid(arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      g_q            <= '0;
      work_q         <= '0;
      ideal_q        <= '0;
      qcnt_q         <= '0;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      done_zone_q    <= '0;
      done_reached_q <= 1'b0;
      done_aborted_q <= 1'b0;
      ac_step_q      <= 1'b0;
      ac_temp_q      <= '0;
      ac_ideal_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            g_q     <= arb_idx;
            grant_q <= arb_gnt;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          work_q     <= sel_temp;
          ideal_q    <= sel_ideal;
          qcnt_q     <= 4'(QUANTUM);
          ac_step_q  <= 1'b1;
          ac_temp_q  <= sel_temp;
          ac_ideal_q <= sel_ideal;
          state_q    <= StStep;
        end
        StStep: begin
          ac_step_q <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          work_q <= ac_out_temp;
          qcnt_q <= qcnt_q - 4'd1;
          if (!sel_en || (ac_out_temp == ideal_q) || (qcnt_q == 4'd1)) begin
            done_q         <= 1'b1;
            done_zone_q    <= 3'(g_q);
            done_reached_q <= (ac_out_temp == ideal_q);
            done_aborted_q <= !sel_en;
            state_q        <= StRelease;
          end else begin
            ac_step_q <= 1'b1;
            ac_temp_q <= ac_out_temp;
            state_q   <= StStep;
          end
        end
        StRelease: begin
          done_q         <= 1'b0;
          done_zone_q    <= '0;
          done_reached_q <= 1'b0;
          done_aborted_q <= 1'b0;
          grant_q        <= '0;
          busy_q         <= 1'b0;
          rr_ptr_q       <= (32'(g_q) == NZ - 1) ? '0 : g_q + 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ac_temp      = ac_temp_q;
  assign ac_ideal     = ac_ideal_q;
  assign ac_step      = ac_step_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign done_zone    = done_zone_q;
  assign done_reached = done_reached_q;
  assign done_aborted = done_aborted_q;
  assign cur_temp     = work_q;

endmodule

// File: tb/tb_ac_zone_scheduler.sv
// Self-checking bench: directed scenarios plus randomized grants checked against
// a transaction-level model of zone selection and engine stepping.
module tb_ac_zone_scheduler;

  localparam int NZ      = 4;
  localparam int W       = 6;
  localparam int QUANTUM = 4;
  localparam int HYST    = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NZ*W-1:0] zone_temp, zone_ideal;
  logic [NZ-1:0]   zone_en;
  logic [W-1:0]    ac_temp, ac_ideal, ac_out_temp, cur_temp;
  logic            ac_step, busy, done, done_reached, done_aborted;
  logic [NZ-1:0]   grant;
  logic [2:0]      done_zone;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;
  bit stuck = 0;
  bit scramble = 0;
  logic [W-1:0] eng_out = '0;

  always #5 clk = ~clk;

  ac_zone_scheduler #(
    .NZ(NZ), .W(W), .QUANTUM(QUANTUM), .HYST(HYST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zone_temp   (zone_temp),
    .zone_ideal  (zone_ideal),
    .zone_en     (zone_en),
    .ac_temp     (ac_temp),
    .ac_ideal    (ac_ideal),
    .ac_step     (ac_step),
    .ac_out_temp (ac_out_temp),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .done_zone   (done_zone),
    .done_reached(done_reached),
    .done_aborted(done_aborted),
    .cur_temp    (cur_temp)
  );

  function automatic int toward(int t, int i);
    if (t < i) return t + 1;
    if (t > i) return t - 1;
    return t;
  endfunction

  // Engine: one unit toward the ideal per strobe, or frozen when stuck.
  always @(posedge clk) begin
    if (ac_step) eng_out <= stuck ? ac_temp : W'(toward(int'(ac_temp), int'(ac_ideal)));
  end
  assign ac_out_temp = eng_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int tget(int i);
    return int'(zone_temp[i*W +: W]);
  endfunction

  function automatic int iget(int i);
    return int'(zone_ideal[i*W +: W]);
  endfunction

  task automatic set_zone(input int i, input int t, input int d, input bit e);
    zone_temp[i*W +: W]  = W'(t);
    zone_ideal[i*W +: W] = W'(d);
    zone_en[i]           = e;
  endtask

  function automatic int pick();
    for (int k = 0; k < NZ; k++) begin
      int j, d;
      j = (ptr_m + k) % NZ;
      d = (tget(j) > iget(j)) ? tget(j) - iget(j) : iget(j) - tget(j);
      if (zone_en[j] && d > HYST) return j;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_grant"}, 32'(grant), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_dzone"}, 32'(done_zone), 0);
    check_eq({tag, "_dreach"}, 32'(done_reached), 0);
    check_eq({tag, "_dabort"}, 32'(done_aborted), 0);
    check_eq({tag, "_step"}, 32'(ac_step), 0);
    check_eq({tag, "_actemp"}, 32'(ac_temp), 0);
    check_eq({tag, "_acideal"}, 32'(ac_ideal), 0);
    check_eq({tag, "_cur"}, 32'(cur_temp), 0);
  endtask

  // Called at the falling edge inside an IDLE cycle with inputs already set;
  // returns at the falling edge of the following IDLE cycle.
  task automatic serve(input int abort_step, output int g, output int steps);
    int  work, ideal, r;
    bit  aborted, reached, fin;
    g = pick();
    steps = 0;
    if (g < 0) begin
      tick();
      check_eq("idle_grant", 32'(grant), 0);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_step", 32'(ac_step), 0);
      return;
    end
    work  = tget(g);
    ideal = iget(g);
    tick();
    check_eq("load_grant", 32'(grant), 32'(1) << g);
    check_eq("load_busy", 32'(busy), 1);
    check_eq("load_step", 32'(ac_step), 0);
    fin = 0;
    aborted = 0;
    reached = 0;
    for (int s = 1; s <= QUANTUM && !fin; s++) begin
      tick();
      check_eq("step_strobe", 32'(ac_step), 1);
      check_eq("step_actemp", 32'(ac_temp), 32'(work));
      check_eq("step_acideal", 32'(ac_ideal), 32'(ideal));
      check_eq("step_cur", 32'(cur_temp), 32'(work));
      if (scramble) begin
        for (int i = 0; i < NZ; i++) begin
          zone_temp[i*W +: W]  = W'($urandom_range(0, 63));
          zone_ideal[i*W +: W] = W'($urandom_range(0, 63));
        end
      end
      if (s == abort_step) zone_en[g] = 1'b0;
      r = stuck ? work : toward(work, ideal);
      steps++;
      tick();
      check_eq("wait_strobe", 32'(ac_step), 0);
      check_eq("wait_acthold", 32'(ac_temp), 32'(work));
      check_eq("wait_busy", 32'(busy), 1);
      check_eq("wait_done", 32'(done), 0);
      aborted = !zone_en[g];
      work    = r;
      reached = (r == ideal);
      fin     = aborted || reached || (s == QUANTUM);
    end
    tick();
    check_eq("rel_done", 32'(done), 1);
    check_eq("rel_zone", 32'(done_zone), 32'(g));
    check_eq("rel_reached", 32'(done_reached), 32'(reached));
    check_eq("rel_aborted", 32'(done_aborted), 32'(aborted));
    check_eq("rel_cur", 32'(cur_temp), 32'(work));
    check_eq("rel_grant", 32'(grant), 32'(1) << g);
    check_eq("rel_step", 32'(ac_step), 0);
    ptr_m = (g + 1) % NZ;
    tick();
    check_eq("post_done", 32'(done), 0);
    check_eq("post_busy", 32'(busy), 0);
    check_eq("post_grant", 32'(grant), 0);
    check_eq("post_cur", 32'(cur_temp), 32'(work));
  endtask

  initial begin
    int g, steps;
    int exp_order[4];
    rst_n      = 1'b0;
    zone_temp  = '0;
    zone_ideal = '0;
    zone_en    = '0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Zones 1 and 3 request continuously from reset: alternate 1,3,1,3.
    exp_order = '{1, 3, 1, 3};
    set_zone(1, 10, 40, 1'b1);
    set_zone(3, 50, 20, 1'b1);
    for (int n = 0; n < 4; n++) begin
      serve(0, g, steps);
      check_eq("rr_order", 32'(g), 32'(exp_order[n]));
    end

    // Zone 2 inside the hysteresis band is never served.
    zone_en = '0;
    set_zone(2, 26, 27, 1'b1);
    for (int n = 0; n < 4; n++) serve(0, g, steps);

    // Zone 0 far from ideal: quantum exhausted, then re-granted from the input.
    zone_en = '0;
    set_zone(0, 17, 27, 1'b1);
    serve(0, g, steps);
    check_eq("z0_steps", 32'(steps), 4);
    check_eq("z0_cur", 32'(cur_temp), 21);
    serve(0, g, steps);
    check_eq("z0_regrant", 32'(g), 0);

    // Zone 1 two away: reaches ideal in two steps.
    zone_en = '0;
    set_zone(1, 25, 27, 1'b1);
    serve(0, g, steps);
    check_eq("z1_steps", 32'(steps), 2);
    check_eq("z1_cur", 32'(cur_temp), 27);

    // Zone 0 disabled during its second step.
    zone_en = '0;
    set_zone(0, 17, 27, 1'b1);
    serve(2, g, steps);
    check_eq("abort_zone", 32'(g), 0);
    check_eq("abort_steps", 32'(steps), 2);

    // Asynchronous reset during WAIT: outputs clear, no done, pointer back to 0.
    zone_en = '0;
    set_zone(0, 30, 40, 1'b1);
    set_zone(2, 30, 40, 1'b1);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    check_eq("rst_hold_done", 32'(done), 0);
    tick();
    check_eq("rst_hold_done2", 32'(done), 0);
    check_eq("rst_hold_busy", 32'(busy), 0);
    rst_n = 1'b1;
    ptr_m = 0;
    serve(0, g, steps);
    check_eq("rst_first_zone", 32'(g), 0);

    // Randomized grants, with stuck engines, aborts and input churn mid-grant.
    scramble = 1;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NZ; i++) begin
        int d, t;
        d = $urandom_range(0, 63);
        case ($urandom_range(0, 2))
          0:       t = d;
          1:       t = (d + int'($urandom_range(0, 4)) > 63) ? 63 : d + int'($urandom_range(0, 4));
          default: t = $urandom_range(0, 63);
        endcase
        set_zone(i, t, d, ($urandom_range(0, 3) != 0));
      end
      stuck = ($urandom_range(0, 4) == 0);
      serve(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, QUANTUM)) : 0, g, steps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
